sfx_sequencer: RTL
==================

Name: sfx_sequencer

Overview:
Sound-effect controller that fills the sound-unit slot of the top level. It takes one-bit effect request strobes from the Nios PIO exports (shoot, jump, hit, explosion) and arbitrates them by fixed priority. For the winning effect it steps through a note table held in an external synchronous ROM and drives a 1-bit square wave to a GPIO pin. It owns the single tone generator and shares it between all requesters, with pre-emption and queuing.

Parameters:
TICK_DIV, 500000, clocks per duration tick (10 ms at 50 MHz); minimum 2
TONE_UNIT, 64, clocks per half-period unit; minimum 1
NUM_STEPS, 8, maximum table steps per effect (power of 2)

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high
enable  in  1  sound master enable from PIO
sfx_req  in  4  request levels; bit3 highest priority (explosion), bit0 lowest (shoot)
tbl_addr  out  5  ROM address = {sfx_id[1:0], step[2:0]}
tbl_data  in  16  ROM word: [15] last, [14:11] dur ticks, [10:0] half-period in TONE_UNITs (0 = rest)
audio_out  out  1  square wave to GPIO
busy  out  1  1 in any state other than IDLE
cur_sfx  out  2  id of effect playing; holds last value when idle

Behaviour:
- Reset values: audio_out=0, busy=0, cur_sfx=0, tbl_addr=0, pending=0, req_d=0, state=IDLE, all counters 0.
- Request detection: req_d registers sfx_req. A rising edge (sfx_req & ~req_d) sets the matching pending bit on the next clock. Held levels do not retrigger.
- Select: sel = index of the highest set pending bit.
- FSM states: IDLE, FETCH, LOAD, PLAY.
- IDLE: if pending != 0, go to FETCH. In that transition set cur_sfx=sel, step=0, clear pending[sel], drive tbl_addr={sel,3'd0}.
- FETCH: ROM has 1-cycle latency; this state waits one cycle, then goes to LOAD.
- LOAD: latch last, dur and hp from tbl_data. If dur=0, the step is skipped and handled like step end (below). Otherwise go to PLAY and clear the tick, dur and tone counters. audio_out=0.
- PLAY: the tick counter counts 0..TICK_DIV-1. dur_cnt increments at each wrap. When dur_cnt reaches dur, the step ends. A step therefore lasts exactly dur*TICK_DIV clocks in PLAY.
- Tone: if hp != 0, audio_out toggles every hp*TONE_UNIT clocks of PLAY, with the first toggle (0->1) after hp*TONE_UNIT clocks. If hp=0, audio_out is held 0.
- Step end:
  - If last=1, or step=NUM_STEPS-1, the effect is done: audio_out=0, go to IDLE. Pending work is taken on the next cycle.
  - Otherwise step+1, drive tbl_addr={cur_sfx, step+1}, go to FETCH.
- Pre-emption: in FETCH/LOAD/PLAY, a pending bit with index > cur_sfx aborts the current effect next cycle. This is the same action as IDLE-with-pending (clear audio_out, load sel, go to FETCH). The aborted effect is dropped, not resumed.
- Retrigger: a rising edge on the currently playing effect's bit restarts it from step 0 on the next cycle.
- Queuing: lower or equal-priority edges (other ids) stay pending and play in priority order after completion. Pending bits for the same id coalesce into one.
- Simultaneous edge and selection on the same id in one cycle: selection clears the bit and the edge does not re-set it; the effect plays once.
- enable=0: takes effect synchronously next cycle and overrides everything. It forces IDLE, audio_out=0, busy=0 and clears pending. Edges are ignored while enable=0, but req_d keeps tracking.
- Reset mid-effect: all state returns to reset values immediately (asynchronous).

Test Plan:
Bench parameters: TICK_DIV=16, TONE_UNIT=1, behavioural 1-cycle ROM.
1. ROM sfx0: {last=1, dur=2, hp=4}. Pulse sfx_req[0] at cycle 0 -> busy=1 at cycle 2, PLAY from cycle 4 for 32 cycles; audio_out toggles every 4 cycles (8 toggles, first at 4 cycles into PLAY); busy=0 and audio_out=0 afterwards.
2. sfx1 is 3 steps: (dur=1, hp=2), (dur=0), (last, dur=1, hp=0) -> tbl_addr sequence 8, 9, 10. The dur=0 step adds only FETCH+LOAD cycles. The final step holds audio_out=0 for 16 cycles.
3. Start sfx0, then raise sfx_req[3] mid-PLAY -> the next cycle leaves PLAY, cur_sfx=3, tbl_addr=24; sfx0 never resumes.
4. Raise sfx_req[1] and sfx_req[2] in the same cycle while idle -> sfx2 plays first, then sfx1. Holding both high does not replay either.
5. Drop enable during PLAY -> next cycle audio_out=0, busy=0, pending=0. Edges arriving while enable=0 produce no playback after re-enable.
6. Assert reset mid-PLAY -> outputs are at reset values before the next clock edge. Retrigger sfx0 during its own PLAY -> it restarts at tbl_addr=0.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Fixed-priority sound-effect sequencer: plays note tables from a 1-cycle ROM
// on a single square-wave tone generator, with pre-emption, retrigger and queuing.
module sfx_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int TONE_UNIT = 64,
  parameter int NUM_STEPS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [3:0]                      sfx_req,
  output logic [$clog2(NUM_STEPS)+1:0]    tbl_addr,
  input  logic [15:0]                     tbl_data,
  output logic                            audio_out,
  output logic                            busy,
  output logic [1:0]                      cur_sfx
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TONE_W = 12 + $clog2(TONE_UNIT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t              state_reg;
  logic [3:0]          req_d_reg;
  logic [3:0]          pending_reg;
  logic [STEP_W-1:0]   step_reg;
  logic                last_reg;
  logic [3:0]          dur_reg;
  logic [10:0]         hp_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [3:0]          dur_cnt_reg;
  logic [TONE_W-1:0]   tone_cnt_reg;

  logic [3:0]          rise;
  logic [3:0]          hold_mask;
  logic [3:0]          sel_onehot;
  logic [1:0]          sel;
  logic [TONE_W-1:0]   tone_limit;
  logic                start;
  logic                tick_wrap;
  logic                step_end;
  logic                effect_done;
  logic [STEP_W-1:0]   step_next;

  assign rise = sfx_req & ~req_d_reg;

  // Pending bits at or above the playing id abort it (equal id = retrigger).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hold
      assign hold_mask[gi] = pending_reg[gi] && (2'(gi) >= cur_sfx);
    end
  endgenerate

  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pending_reg[i]) sel = 2'(i);
    end
  end

  assign sel_onehot  = 4'b0001 << sel;
  assign start       = (state_reg == IDLE) ? (pending_reg != 4'd0) : (hold_mask != 4'd0);
  assign tick_wrap   = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
  assign tone_limit  = TONE_W'(hp_reg) * TONE_W'(TONE_UNIT);
  assign step_next   = step_reg + STEP_W'(1);

  // A zero-duration row ends its step straight out of LOAD.
  assign step_end    = ((state_reg == LOAD) && (tbl_data[14:11] == 4'd0)) ||
                       ((state_reg == PLAY) && tick_wrap && ((dur_cnt_reg + 4'd1) == dur_reg));
  assign effect_done = ((state_reg == LOAD) ? tbl_data[15] : last_reg) ||
                       (step_reg == STEP_W'(NUM_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      req_d_reg    <= 4'd0;
      pending_reg  <= 4'd0;
      step_reg     <= '0;
      last_reg     <= 1'b0;
      dur_reg      <= 4'd0;
      hp_reg       <= 11'd0;
      tick_cnt_reg <= '0;
      dur_cnt_reg  <= 4'd0;
      tone_cnt_reg <= '0;
      tbl_addr     <= '0;
      audio_out    <= 1'b0;
      busy         <= 1'b0;
      cur_sfx      <= 2'd0;
    end else begin
      req_d_reg <= sfx_req;
      if (!enable) begin
        state_reg   <= IDLE;
        audio_out   <= 1'b0;
        busy        <= 1'b0;
        pending_reg <= 4'd0;
      end else begin
        // Selection wins over a same-cycle edge on the selected id.
        pending_reg <= (pending_reg | rise) & ~(start ? sel_onehot : 4'd0);
        if (start) begin
          state_reg <= FETCH;
          busy      <= 1'b1;
          audio_out <= 1'b0;
          cur_sfx   <= sel;
          step_reg  <= '0;
          tbl_addr  <= {sel, {STEP_W{1'b0}}};
        end else begin
          case (state_reg)
            IDLE:  ;
            FETCH: state_reg <= LOAD;
            LOAD: begin
              last_reg     <= tbl_data[15];
              dur_reg      <= tbl_data[14:11];
              hp_reg       <= tbl_data[10:0];
              audio_out    <= 1'b0;
              state_reg    <= PLAY;
              tick_cnt_reg <= '0;
              dur_cnt_reg  <= 4'd0;
              tone_cnt_reg <= '0;
            end
            PLAY: begin
              tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + TICK_W'(1);
              if (tick_wrap) dur_cnt_reg <= dur_cnt_reg + 4'd1;
              if (hp_reg == 11'd0) begin
                audio_out <= 1'b0;
              end else if (tone_cnt_reg == tone_limit - TONE_W'(1)) begin
                audio_out    <= ~audio_out;
                tone_cnt_reg <= '0;
              end else begin
                tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
              end
            end
            default: state_reg <= IDLE;
          endcase
          if (step_end) begin
            audio_out <= 1'b0;
            if (effect_done) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg <= FETCH;
              step_reg  <= step_next;
              tbl_addr  <= {cur_sfx, step_next};
            end
          end
        end
      end
    end
  end

endmodule
